// File: rtl/item_table_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : item_table_ctrl_if                                          |
// | Brief  : Request/response bundle between the command FSM and the     |
// |          item-table sequencing controller.                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface item_table_ctrl_if #(
  parameter int NAME_NUM_BITS = 56,
  parameter int STOCK_BITS    = 8,
  parameter int USER_BITS     = 4,
  parameter int COUNT_BITS    = 4
);
  logic                     i_req;
  logic [1:0]               i_op;
  logic [NAME_NUM_BITS-1:0] i_name;
  logic [STOCK_BITS-1:0]    i_stock;
  logic [USER_BITS-1:0]     i_user;
  logic                     o_busy;
  logic                     o_done;
  logic [2:0]               o_status;
  logic [STOCK_BITS-1:0]    o_stock;
  logic [COUNT_BITS-1:0]    o_count;

  // Command side: issues requests, observes results
  modport master (
    output i_req, i_op, i_name, i_stock, i_user,
    input  o_busy, o_done, o_status, o_stock, o_count
  );

  // Controller side
  modport slave (
    input  i_req, i_op, i_name, i_stock, i_user,
    output o_busy, o_done, o_status, o_stock, o_count
  );
endinterface
`default_nettype wire

// File: rtl/item_table_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : item_table_ctrl                                             |
// | Brief  : Item table (name/stock/owner) with FIND/ADD/DEL/BUY ops.    |
// |          Each op scans all entries one per cycle, then commits.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module item_table_ctrl #(
  parameter int MAX_ITEMS            = 8,
  parameter int NAME_NUM_ASCII_CHARS = 7,
  parameter int NAME_NUM_BITS        = NAME_NUM_ASCII_CHARS*8,
  parameter int STOCK_BITS           = 8,
  parameter int USER_BITS            = 4,
  parameter int COUNT_BITS           = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  item_table_ctrl_if.slave bus
);
  localparam int                IDX_BITS = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MAX_ITEMS - 1);

  localparam logic [1:0] OP_FIND = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_DEL  = 2'd2;
  localparam logic [1:0] OP_BUY  = 2'd3;

  localparam logic [2:0] STS_OK        = 3'd0;
  localparam logic [2:0] STS_FULL      = 3'd1;
  localparam logic [2:0] STS_EXISTS    = 3'd2;
  localparam logic [2:0] STS_UNKNOWN   = 3'd3;
  localparam logic [2:0] STS_NOT_OWNER = 3'd4;
  localparam logic [2:0] STS_NO_STOCK  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Table storage; only the valid bits need a reset value
  logic [MAX_ITEMS-1:0]     valid;
  logic [NAME_NUM_BITS-1:0] name_tab  [MAX_ITEMS];
  logic [STOCK_BITS-1:0]    stock_tab [MAX_ITEMS];
  logic [USER_BITS-1:0]     owner_tab [MAX_ITEMS];

  // Request captured at acceptance so later input changes are ignored
  logic [1:0]               op_q;
  logic [NAME_NUM_BITS-1:0] name_q;
  logic [STOCK_BITS-1:0]    stock_q;
  logic [USER_BITS-1:0]     user_q;

  logic [IDX_BITS-1:0]      idx, match_idx, free_idx;
  logic                     match_found, free_found;

  logic                     done_q;
  logic [2:0]               status_q;
  logic [STOCK_BITS-1:0]    stock_out;
  logic [COUNT_BITS-1:0]    count;

  logic [2:0]               exec_status;
  logic [STOCK_BITS-1:0]    exec_stock, tgt_stock;
  logic                     do_add, do_del, do_buy;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state: accept while idle, full fixed-length scan, one commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.i_req) state_nxt = ST_SCAN;
      ST_SCAN: if (idx == LAST_IDX) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and scan: first name match, lowest free slot
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      op_q        <= OP_FIND;
      name_q      <= '0;
      stock_q     <= '0;
      user_q      <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.i_req) begin
        op_q        <= bus.i_op;
        name_q      <= bus.i_name;
        stock_q     <= bus.i_stock;
        user_q      <= bus.i_user;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
      end
    end else if (state == ST_SCAN) begin
      if (valid[idx] && (name_tab[idx] == name_q) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!valid[idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      idx <= idx + IDX_BITS'(1);
    end
  end

  // Commit decision from the scan result, in each op's priority order
  always_comb begin
    exec_status = STS_OK;
    exec_stock  = '0;
    do_add      = 1'b0;
    do_del      = 1'b0;
    do_buy      = 1'b0;
    tgt_stock   = stock_tab[match_idx];
    case (op_q)
      OP_FIND: begin
        if (match_found) exec_stock  = tgt_stock;
        else             exec_status = STS_UNKNOWN;
      end
      OP_ADD: begin
        if (match_found)      exec_status = STS_EXISTS;
        else if (!free_found) exec_status = STS_FULL;
        else begin
          do_add     = 1'b1;
          exec_stock = stock_q;
        end
      end
      OP_DEL: begin
        if (!match_found) exec_status = STS_UNKNOWN;
        else if ((owner_tab[match_idx] != user_q) && (user_q != '0)) begin
          exec_status = STS_NOT_OWNER;
          exec_stock  = tgt_stock;
        end else begin
          do_del = 1'b1;
        end
      end
      OP_BUY: begin
        if (!match_found) exec_status = STS_UNKNOWN;
        else if (tgt_stock == '0) exec_status = STS_NO_STOCK;
        else begin
          do_buy     = 1'b1;
          exec_stock = tgt_stock - STOCK_BITS'(1);
        end
      end
      default: exec_status = STS_OK;
    endcase
  end

  // Valid bits: set on ADD, cleared on DEL, all cleared by reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid <= '0;
    end else if (state == ST_EXEC) begin
      if (do_add) valid[free_idx]  <= 1'b1;
      if (do_del) valid[match_idx] <= 1'b0;
    end
  end

  // Entry payload writes; gated by reset so an aborted op leaves no trace
  always_ff @(posedge i_clk) begin
    if (i_reset_n && (state == ST_EXEC)) begin
      if (do_add) begin
        name_tab[free_idx]  <= name_q;
        stock_tab[free_idx] <= stock_q;
        owner_tab[free_idx] <= user_q;
      end
      if (do_buy) stock_tab[match_idx] <= exec_stock;
    end
  end

  // Result registers: held until the next commit
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      done_q    <= 1'b0;
      status_q  <= STS_OK;
      stock_out <= '0;
      count     <= '0;
    end else begin
      done_q <= (state == ST_EXEC);
      if (state == ST_EXEC) begin
        status_q  <= exec_status;
        stock_out <= exec_stock;
        if (do_add) count <= count + COUNT_BITS'(1);
        if (do_del) count <= count - COUNT_BITS'(1);
      end
    end
  end

  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_status = status_q;
  assign bus.o_stock  = stock_out;
  assign bus.o_count  = count;

endmodule
`default_nettype wire

// File: tb/tb_item_table_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_item_table_ctrl                                          |
// | Brief  : Directed self-checking bench for item_table_ctrl.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_item_table_ctrl;
  localparam logic [1:0] FIND = 2'd0, ADD = 2'd1, DEL = 2'd2, BUY = 2'd3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  item_table_ctrl_if #(.NAME_NUM_BITS(56), .STOCK_BITS(8), .USER_BITS(4), .COUNT_BITS(4)) bus ();

  item_table_ctrl dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one op; returns result, latency in edges after acceptance, busy seen
  task automatic do_op(input logic [1:0] op, input logic [55:0] nm, input logic [7:0] stk,
                       input logic [3:0] usr, output logic [2:0] st, output logic [7:0] sk,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_op = op; bus.i_name = nm; bus.i_stock = stk; bus.i_user = usr;
    @(posedge clk); #1;
    busy_ok = (bus.o_busy === 1'b1);
    bus.i_req = 1'b0; bus.i_op = ~op; bus.i_name = '1; bus.i_stock = 8'hEE; bus.i_user = 4'hF;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) begin lat = c; break; end
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
    end
    st = bus.o_status; sk = bus.o_stock;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0; bus.i_req = 1'b1; bus.i_op = ADD;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", bus.o_done); end
    checks++; if (bus.o_status !== 3'd0 || bus.o_stock !== 8'd0 || bus.o_count !== 4'd0) begin
      fails++; $display("FAIL reset_outputs got status=%0d stock=%0d count=%0d want 0/0/0", bus.o_status, bus.o_stock, bus.o_count); end
    @(negedge clk); bus.i_req = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_add_first();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz;
    do_op(ADD, "Lamp", 8'd3, 4'd2, st, sk, lat, bz);
    checks++; if (lat !== 9) begin fails++; $display("FAIL add_latency got %0d want 9", lat); end
    checks++; if (!bz) begin fails++; $display("FAIL add_busy got busy-drop want busy held"); end
    checks++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL add_busy_end got %0b want 0", bus.o_busy); end
    checks++; if (st !== 3'd0 || sk !== 8'd3 || bus.o_count !== 4'd1) begin
      fails++; $display("FAIL add_lamp got st=%0d sk=%0d cnt=%0d want 0/3/1", st, sk, bus.o_count); end
    @(posedge clk); #1;
    checks++; if (bus.o_done !== 1'b0 || bus.o_status !== 3'd0 || bus.o_stock !== 8'd3) begin
      fails++; $display("FAIL done_pulse_hold got done=%0b st=%0d sk=%0d want 0/0/3", bus.o_done, bus.o_status, bus.o_stock); end
  endtask

  task automatic test_exists();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz;
    do_op(ADD, "Lamp", 8'd9, 4'd1, st, sk, lat, bz);
    checks++; if (st !== 3'd2 || sk !== 8'd0 || bus.o_count !== 4'd1) begin
      fails++; $display("FAIL add_exists got st=%0d sk=%0d cnt=%0d want 2/0/1", st, sk, bus.o_count); end
  endtask

  task automatic test_buy();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz;
    logic [2:0] exp_st [4] = '{3'd0, 3'd0, 3'd0, 3'd5};
    logic [7:0] exp_sk [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      do_op(BUY, "Lamp", 8'd0, 4'd2, st, sk, lat, bz);
      checks++; if (st !== exp_st[i] || sk !== exp_sk[i]) begin
        fails++; $display("FAIL buy_%0d got st=%0d sk=%0d want %0d/%0d", i, st, sk, exp_st[i], exp_sk[i]); end
    end
  endtask

  task automatic test_delete();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz;
    do_op(DEL, "Lamp", 8'd0, 4'd3, st, sk, lat, bz);
    checks++; if (st !== 3'd4 || bus.o_count !== 4'd1) begin
      fails++; $display("FAIL del_not_owner got st=%0d cnt=%0d want 4/1", st, bus.o_count); end
    do_op(DEL, "Lamp", 8'd0, 4'd0, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || sk !== 8'd0 || bus.o_count !== 4'd0) begin
      fails++; $display("FAIL del_admin got st=%0d sk=%0d cnt=%0d want 0/0/0", st, sk, bus.o_count); end
    do_op(FIND, "Lamp", 8'd0, 4'd2, st, sk, lat, bz);
    checks++; if (st !== 3'd3 || sk !== 8'd0) begin
      fails++; $display("FAIL find_deleted got st=%0d sk=%0d want 3/0", st, sk); end
  endtask

  task automatic test_fill();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz; int bad;
    logic [55:0] nm;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      nm = {"Item", 8'(8'h30 + i)};
      do_op(ADD, nm, 8'(10 + i), 4'd1, st, sk, lat, bz);
      if (st !== 3'd0 || sk !== 8'(10 + i)) bad++;
    end
    checks++; if (bad != 0 || bus.o_count !== 4'd8) begin
      fails++; $display("FAIL fill_8 got bad=%0d cnt=%0d want 0/8", bad, bus.o_count); end
    do_op(ADD, "Extra", 8'd1, 4'd1, st, sk, lat, bz);
    checks++; if (st !== 3'd1 || sk !== 8'd0 || bus.o_count !== 4'd8) begin
      fails++; $display("FAIL add_full got st=%0d sk=%0d cnt=%0d want 1/0/8", st, sk, bus.o_count); end
    do_op(DEL, "Item2", 8'd0, 4'd1, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || bus.o_count !== 4'd7) begin
      fails++; $display("FAIL del_slot2 got st=%0d cnt=%0d want 0/7", st, bus.o_count); end
    do_op(ADD, "Cup", 8'd5, 4'd4, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || sk !== 8'd5 || bus.o_count !== 4'd8) begin
      fails++; $display("FAIL add_cup got st=%0d sk=%0d cnt=%0d want 0/5/8", st, sk, bus.o_count); end
    do_op(FIND, "Cup", 8'd0, 4'd0, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || sk !== 8'd5) begin
      fails++; $display("FAIL find_cup got st=%0d sk=%0d want 0/5", st, sk); end
    do_op(FIND, "Item3", 8'd0, 4'd0, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || sk !== 8'd13) begin
      fails++; $display("FAIL find_item3 got st=%0d sk=%0d want 0/13", st, sk); end
    do_op(BUY, "Cup", 8'd0, 4'd4, st, sk, lat, bz);
    checks++; if (st !== 3'd0 || sk !== 8'd4) begin
      fails++; $display("FAIL owner_buy got st=%0d sk=%0d want 0/4", st, sk); end
    do_op(DEL, "Cup", 8'd0, 4'd1, st, sk, lat, bz);
    checks++; if (st !== 3'd4 || sk !== 8'd4 || bus.o_count !== 4'd8) begin
      fails++; $display("FAIL del_cup_other got st=%0d sk=%0d cnt=%0d want 4/4/8", st, sk, bus.o_count); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] st; logic [7:0] sk; int lat; bit bz; int dones;
    apply_reset();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_op = ADD; bus.i_name = "Pen"; bus.i_stock = 8'd7; bus.i_user = 4'd1;
    @(posedge clk);               // edge k: accepted
    @(negedge clk); bus.i_req = 1'b0;
    repeat (3) @(posedge clk);    // edges k+1..k+3
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk);               // edge k+4 under reset
    @(negedge clk); reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) dones++;
    end
    checks++; if (dones != 0 || bus.o_count !== 4'd0 || bus.o_busy !== 1'b0) begin
      fails++; $display("FAIL reset_abort got dones=%0d cnt=%0d busy=%0b want 0/0/0", dones, bus.o_count, bus.o_busy); end
    do_op(FIND, "Pen", 8'd0, 4'd1, st, sk, lat, bz);
    checks++; if (st !== 3'd3) begin fails++; $display("FAIL find_pen got st=%0d want 3", st); end
  endtask

  task automatic test_back_to_back();
    int dones; int first; int last;
    dones = 0; first = -1; last = -1;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_op = ADD; bus.i_name = "Pen"; bus.i_stock = 8'd1; bus.i_user = 4'd1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) begin
        dones++;
        if (first < 0) first = e;
        last = e;
      end
    end
    @(negedge clk); bus.i_req = 1'b0;
    repeat (12) @(posedge clk); #1;
    checks++; if (dones != 3 || first != 9 || last != 29) begin
      fails++; $display("FAIL b2b_dones got n=%0d first=%0d last=%0d want 3/9/29", dones, first, last); end
    // First ADD succeeds, the two repeats see the existing name
    checks++; if (bus.o_count !== 4'd1 || bus.o_status !== 3'd2 || bus.o_busy !== 1'b0) begin
      fails++; $display("FAIL b2b_state got cnt=%0d st=%0d busy=%0b want 1/2/0", bus.o_count, bus.o_status, bus.o_busy); end
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_op = FIND; bus.i_name = '0; bus.i_stock = '0; bus.i_user = '0;
    test_reset();
    test_add_first();
    test_exists();
    test_buy();
    test_delete();
    test_fill();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
